wb_trap_ctrl: RTL and testbench

Writeback-stage trap controller that sits directly upstream of the CSR file. Each cycle it looks at the instruction retiring in writeback, its exception flags, the current `mstatus`/`mie`/`mip` values and three synchronized interrupt lines. From these it produces the one-hot trap strobes the CSR file consumes (`wb2csrfile_*`). It also produces the pipeline flush and the fetch redirect (trap vector or `mepc`), and holds off new traps while the pipeline drains.

---
 rtl/wb_trap_ctrl_if.sv | 39 +++
 rtl/wb_trap_ctrl.sv | 133 +++++++++++++
 tb/tb_wb_trap_ctrl.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/wb_trap_ctrl_if.sv
// Bundle between writeback/CSR state and the trap controller.
// slave  : seen by wb_trap_ctrl (retire info + CSR values in, strobes/redirect out)
// master : seen by the driver of retire info / consumer of strobes
interface wb_trap_ctrl_if;
  logic        mem2wb_valid_ffout;
  logic        mem2wb_mret_ffout;
  logic        mem2wb_e_iam, mem2wb_e_ii, mem2wb_e_bk, mem2wb_e_lam, mem2wb_e_ecfm;
  logic        irq_ext, irq_tmr, irq_sw;
  logic [31:0] mstatus, mie, mip, mtvec, mepc;
  logic        wb2csrfile_exp, wb2csrfile_int, wb2csrfile_mret;
  logic        wb2csrfile_i_ms, wb2csrfile_i_mt, wb2csrfile_i_me;
  logic        wb2csrfile_e_iam, wb2csrfile_e_ii, wb2csrfile_e_bk;
  logic        wb2csrfile_e_lam, wb2csrfile_e_ecfm;
  logic        flush;
  logic        redirect_vld;
  logic [31:0] redirect_pc;

  modport slave (
    input  mem2wb_valid_ffout, mem2wb_mret_ffout,
           mem2wb_e_iam, mem2wb_e_ii, mem2wb_e_bk, mem2wb_e_lam, mem2wb_e_ecfm,
           irq_ext, irq_tmr, irq_sw, mstatus, mie, mip, mtvec, mepc,
    output wb2csrfile_exp, wb2csrfile_int, wb2csrfile_mret,
           wb2csrfile_i_ms, wb2csrfile_i_mt, wb2csrfile_i_me,
           wb2csrfile_e_iam, wb2csrfile_e_ii, wb2csrfile_e_bk,
           wb2csrfile_e_lam, wb2csrfile_e_ecfm,
           flush, redirect_vld, redirect_pc
  );

  modport master (
    output mem2wb_valid_ffout, mem2wb_mret_ffout,
           mem2wb_e_iam, mem2wb_e_ii, mem2wb_e_bk, mem2wb_e_lam, mem2wb_e_ecfm,
           irq_ext, irq_tmr, irq_sw, mstatus, mie, mip, mtvec, mepc,
    input  wb2csrfile_exp, wb2csrfile_int, wb2csrfile_mret,
           wb2csrfile_i_ms, wb2csrfile_i_mt, wb2csrfile_i_me,
           wb2csrfile_e_iam, wb2csrfile_e_ii, wb2csrfile_e_bk,
           wb2csrfile_e_lam, wb2csrfile_e_ecfm,
           flush, redirect_vld, redirect_pc
  );
endinterface

// File: rtl/wb_trap_ctrl.sv
// Writeback-stage trap controller. Decides exception / interrupt / mret for
// the retiring instruction, emits one-hot CSR-file strobes (combinational,
// decision cycle only), a registered one-cycle fetch redirect and a pipeline
// flush that lasts FLUSH_CYC cycles, during which no new decision is made.
// Ports:
//   clk       core clock
//   cpurst_n  async active-low reset
//   bus       wb_trap_ctrl_if.slave (retire info, irq lines, CSRs in;
//             strobes, flush, redirect out)
module wb_trap_ctrl #(
  parameter int unsigned FLUSH_CYC = 2   // 1..15
) (
  input  logic               clk,
  input  logic               cpurst_n,
  wb_trap_ctrl_if.slave      bus
);

  typedef enum logic {IDLE, DRAIN} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [2:0]  sync1_q, sync2_q;         // {sw, tmr, ext}
  logic        redirect_vld_q, redirect_vld_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;

  logic        s_ext, s_tmr, s_sw;
  logic        p_me, p_mt, p_ms;
  logic        dec_en, exc_any, exc_take, int_take, mret_take, trap;
  logic [3:0]  int_code;
  logic [31:0] base, target;

  // Two-flop synchronizers for the asynchronous interrupt lines
  always_ff @(posedge clk or negedge cpurst_n) begin
    if (!cpurst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {bus.irq_sw, bus.irq_tmr, bus.irq_ext};
      sync2_q <= sync1_q;
    end
  end

  assign s_ext = sync2_q[0];
  assign s_tmr = sync2_q[1];
  assign s_sw  = sync2_q[2];

  assign p_me = (s_ext | bus.mip[3])  & bus.mie[3];
  assign p_mt = (s_tmr | bus.mip[7])  & bus.mie[7];
  assign p_ms = (s_sw  | bus.mip[11]) & bus.mie[11];

  // Decisions only in IDLE on a valid retire. An eligible interrupt beats a
  // coincident mret; the mret simply retires again after the handler.
  assign dec_en    = (state_q == IDLE) & bus.mem2wb_valid_ffout;
  assign exc_any   = bus.mem2wb_e_iam | bus.mem2wb_e_ii | bus.mem2wb_e_bk |
                     bus.mem2wb_e_lam | bus.mem2wb_e_ecfm;
  assign exc_take  = dec_en & exc_any;
  assign int_take  = dec_en & ~exc_any & bus.mstatus[3] & (p_me | p_mt | p_ms);
  assign mret_take = dec_en & ~exc_any & ~int_take & bus.mem2wb_mret_ffout;
  assign trap      = exc_take | int_take | mret_take;

  // Strobes: priority-encoded to a single cause
  assign bus.wb2csrfile_exp    = exc_take;
  assign bus.wb2csrfile_int    = int_take;
  assign bus.wb2csrfile_mret   = mret_take;
  assign bus.wb2csrfile_e_iam  = exc_take & bus.mem2wb_e_iam;
  assign bus.wb2csrfile_e_ii   = exc_take & ~bus.mem2wb_e_iam & bus.mem2wb_e_ii;
  assign bus.wb2csrfile_e_bk   = exc_take & ~bus.mem2wb_e_iam & ~bus.mem2wb_e_ii &
                                 bus.mem2wb_e_bk;
  assign bus.wb2csrfile_e_lam  = exc_take & ~bus.mem2wb_e_iam & ~bus.mem2wb_e_ii &
                                 ~bus.mem2wb_e_bk & bus.mem2wb_e_lam;
  assign bus.wb2csrfile_e_ecfm = exc_take & ~bus.mem2wb_e_iam & ~bus.mem2wb_e_ii &
                                 ~bus.mem2wb_e_bk & ~bus.mem2wb_e_lam & bus.mem2wb_e_ecfm;
  assign bus.wb2csrfile_i_me   = int_take & p_me;
  assign bus.wb2csrfile_i_ms   = int_take & ~p_me & p_ms;
  assign bus.wb2csrfile_i_mt   = int_take & ~p_me & ~p_ms & p_mt;

  // Vectored target; the add wraps naturally at 32 bits
  assign int_code = p_me ? 4'd11 : (p_ms ? 4'd3 : 4'd7);
  assign base     = {bus.mtvec[31:2], 2'b00};
  always_comb begin
    target = bus.mepc;
    if (exc_take)      target = base;
    else if (int_take) target = base + {26'd0, int_code, 2'b00};
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    redirect_vld_d = trap;
    redirect_pc_d  = trap ? target : redirect_pc_q;
    case (state_q)
      IDLE: if (trap) begin
        state_d = DRAIN;
        cnt_d   = 4'(FLUSH_CYC);
      end
      DRAIN: if (cnt_q <= 4'd1) begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end else begin
        cnt_d   = cnt_q - 4'd1;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge cpurst_n) begin
    if (!cpurst_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      redirect_vld_q <= 1'b0;
      redirect_pc_q  <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      redirect_vld_q <= redirect_vld_d;
      redirect_pc_q  <= redirect_pc_d;
    end
  end

  // flush follows the state flop so reset drops it without a clock edge
  assign bus.flush        = (state_q == DRAIN);
  assign bus.redirect_vld = redirect_vld_q;
  assign bus.redirect_pc  = redirect_pc_q;

  logic unused_csr;
  assign unused_csr = ^{bus.mstatus[31:4], bus.mstatus[2:0], bus.mie[31:12],
                        bus.mie[10:8], bus.mie[6:4], bus.mie[2:0], bus.mip[31:12],
                        bus.mip[10:8], bus.mip[6:4], bus.mip[2:0], bus.mtvec[1:0]};

endmodule

// File: tb/tb_wb_trap_ctrl.sv
module tb_wb_trap_ctrl;
  logic clk, rst_n, rst4_n;
  int   n_cmp = 0, n_err = 0;

  wb_trap_ctrl_if bus();
  wb_trap_ctrl_if bus4();

  wb_trap_ctrl #(.FLUSH_CYC(2)) dut  (.clk(clk), .cpurst_n(rst_n),  .bus(bus.slave));
  wb_trap_ctrl #(.FLUSH_CYC(4)) dut4 (.clk(clk), .cpurst_n(rst4_n), .bus(bus4.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // strobe vector: {exp,int,mret,i_me,i_ms,i_mt,e_iam,e_ii,e_bk,e_lam,e_ecfm}
  localparam logic [31:0] EXP = 32'h400, INT = 32'h200, MRET = 32'h100;
  localparam logic [31:0] IME = 32'h080, IMS = 32'h040, IMT = 32'h020;
  localparam logic [31:0] EII = 32'h008, EBK = 32'h004, ELAM = 32'h002;

  logic [31:0] st, st4;
  assign st  = {21'd0, bus.wb2csrfile_exp, bus.wb2csrfile_int, bus.wb2csrfile_mret,
                bus.wb2csrfile_i_me, bus.wb2csrfile_i_ms, bus.wb2csrfile_i_mt,
                bus.wb2csrfile_e_iam, bus.wb2csrfile_e_ii, bus.wb2csrfile_e_bk,
                bus.wb2csrfile_e_lam, bus.wb2csrfile_e_ecfm};
  assign st4 = {21'd0, bus4.wb2csrfile_exp, bus4.wb2csrfile_int, bus4.wb2csrfile_mret,
                bus4.wb2csrfile_i_me, bus4.wb2csrfile_i_ms, bus4.wb2csrfile_i_mt,
                bus4.wb2csrfile_e_iam, bus4.wb2csrfile_e_ii, bus4.wb2csrfile_e_bk,
                bus4.wb2csrfile_e_lam, bus4.wb2csrfile_e_ecfm};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic clr_in();
    bus.mem2wb_valid_ffout = 0; bus.mem2wb_mret_ffout = 0;
    bus.mem2wb_e_iam = 0; bus.mem2wb_e_ii = 0; bus.mem2wb_e_bk = 0;
    bus.mem2wb_e_lam = 0; bus.mem2wb_e_ecfm = 0;
    bus4.mem2wb_valid_ffout = 0; bus4.mem2wb_mret_ffout = 0;
    bus4.mem2wb_e_iam = 0; bus4.mem2wb_e_ii = 0; bus4.mem2wb_e_bk = 0;
    bus4.mem2wb_e_lam = 0; bus4.mem2wb_e_ecfm = 0;
  endtask

  initial begin
    rst_n = 0; rst4_n = 0;
    clr_in();
    bus.irq_ext = 0; bus.irq_tmr = 0; bus.irq_sw = 0;
    bus.mstatus = 0; bus.mie = 0; bus.mip = 0; bus.mtvec = 0; bus.mepc = 0;
    bus4.irq_ext = 0; bus4.irq_tmr = 0; bus4.irq_sw = 0;
    bus4.mstatus = 0; bus4.mie = 0; bus4.mip = 0; bus4.mtvec = 32'h100; bus4.mepc = 0;
    #1;
    chk("rst_strobe", st, 0);
    chk("rst_flush", {31'd0, bus.flush}, 0);
    chk("rst_rvld", {31'd0, bus.redirect_vld}, 0);
    chk("rst_rpc", bus.redirect_pc, 0);
    cyc(2);
    rst_n = 1; rst4_n = 1;
    cyc();

    // illegal instruction
    bus.mtvec = 32'h8000_0001;
    bus.mem2wb_valid_ffout = 1; bus.mem2wb_e_ii = 1;
    #1 chk("ii_strobe_T", st, EXP | EII);
    chk("ii_flush_T", {31'd0, bus.flush}, 0);
    cyc(); clr_in();
    chk("ii_rvld_T1", {31'd0, bus.redirect_vld}, 1);
    chk("ii_rpc_T1", bus.redirect_pc, 32'h8000_0000);
    chk("ii_flush_T1", {31'd0, bus.flush}, 1);
    chk("ii_strobe_T1", st, 0);
    cyc();
    chk("ii_rvld_T2", {31'd0, bus.redirect_vld}, 0);
    chk("ii_flush_T2", {31'd0, bus.flush}, 1);
    cyc();
    chk("ii_flush_T3", {31'd0, bus.flush}, 0);

    // simultaneous ext + tmr interrupts, valid held high
    bus.mstatus = 32'h8; bus.mie = 32'h888;
    bus.mem2wb_valid_ffout = 1;
    bus.irq_ext = 1; bus.irq_tmr = 1;
    #1 chk("irq_c0", st, 0);
    cyc();
    chk("irq_c1", st, 0);
    cyc();
    chk("irq_c2", st, INT | IME);
    cyc();
    bus.mem2wb_valid_ffout = 0; bus.irq_ext = 0; bus.irq_tmr = 0;
    chk("irq_rvld", {31'd0, bus.redirect_vld}, 1);
    chk("irq_rpc", bus.redirect_pc, 32'h8000_002C);
    cyc(4);

    // exception beats pending timer interrupt; interrupt after drain
    bus.mip = 32'h80;
    bus.mem2wb_valid_ffout = 1; bus.mem2wb_e_lam = 1;
    #1 chk("lam_strobe", st, EXP | ELAM);
    cyc();
    bus.mem2wb_e_lam = 0;
    #1 chk("lam_drain1", st, 0);
    chk("lam_rpc", bus.redirect_pc, 32'h8000_0000);
    cyc();
    chk("lam_drain2", st, 0);
    cyc();
    chk("lam_int_after", st, INT | IMT);
    cyc();
    clr_in(); bus.mip = 0;
    chk("lam_int_rpc", bus.redirect_pc, 32'h8000_001C);
    cyc(3);

    // plain mret
    bus.mepc = 32'h0000_1234;
    bus.mem2wb_valid_ffout = 1; bus.mem2wb_mret_ffout = 1;
    #1 chk("mret_strobe", st, MRET);
    cyc(); clr_in();
    chk("mret_rpc", bus.redirect_pc, 32'h0000_1234);
    chk("mret_rvld", {31'd0, bus.redirect_vld}, 1);
    cyc(3);

    // mret with software interrupt pending: interrupt wins
    bus.mip = 32'h800;
    bus.mem2wb_valid_ffout = 1; bus.mem2wb_mret_ffout = 1;
    #1 chk("mret_ms_strobe", st, INT | IMS);
    cyc(); clr_in(); bus.mip = 0;
    chk("mret_ms_rpc", bus.redirect_pc, 32'h8000_000C);
    cyc(3);

    // global interrupt enable off: no int
    bus.mstatus = 0; bus.mip = 32'h888;
    bus.mem2wb_valid_ffout = 1;
    #1 chk("gate_mie_off", st, 0);
    cyc();
    chk("gate_no_flush", {31'd0, bus.flush}, 0);
    // valid low blocks exceptions
    bus.mem2wb_valid_ffout = 0; bus.mem2wb_e_ii = 1;
    #1 chk("gate_valid_low", st, 0);
    cyc(); clr_in();
    chk("gate_no_rvld", {31'd0, bus.redirect_vld}, 0);

    // vector wrap
    bus.mstatus = 32'h8; bus.mip = 32'h8; bus.mtvec = 32'hFFFF_FFFD;
    bus.mem2wb_valid_ffout = 1;
    #1 chk("wrap_strobe", st, INT | IME);
    cyc(); clr_in(); bus.mip = 0;
    bus.mtvec = 32'h0;   // CSR write after T must not disturb the redirect
    chk("wrap_rpc", bus.redirect_pc, 32'h0000_0028);
    cyc(3);

    // reset mid-DRAIN (FLUSH_CYC=4 instance)
    bus4.mem2wb_valid_ffout = 1; bus4.mem2wb_e_ii = 1;
    #1 chk("r4_strobe", st4, EXP | EII);
    cyc(); clr_in();
    chk("r4_drain1", {31'd0, bus4.flush}, 1);
    cyc();
    chk("r4_drain2", {31'd0, bus4.flush}, 1);
    #1 rst4_n = 0;
    #1 chk("r4_async_flush", {31'd0, bus4.flush}, 0);
    chk("r4_async_rvld", {31'd0, bus4.redirect_vld}, 0);
    chk("r4_async_rpc", bus4.redirect_pc, 0);
    cyc();
    rst4_n = 1;
    bus4.mem2wb_valid_ffout = 1; bus4.mem2wb_e_bk = 1;
    #1 chk("r4_new_exc", st4, EXP | EBK);
    cyc(); clr_in();
    chk("r4_new_rvld", {31'd0, bus4.redirect_vld}, 1);
    chk("r4_new_rpc", bus4.redirect_pc, 32'h100);
    cyc(4);
    chk("r4_flush_done", {31'd0, bus4.flush}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
